// File: rtl/wb_grf_pkg.sv
// Shared MIPS opcode/funct encodings and writeback select types.
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_PC8, WD_HILO} wd_sel_e;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;
endpackage

// File: rtl/wb_grf_load_ext.sv
// Little-endian byte/halfword extractor for loads; purely combinational.
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  addr,
  input  ld_type_e    ld_type,
  output logic [31:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = dr[{addr, 3'b000} +: 8];
    half_v = addr[1] ? dr[31:16] : dr[15:0];
    case (ld_type)
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'h0, byte_v};
      LD_H:    data = {{16{half_v[15]}}, half_v};
      LD_HU:   data = {16'h0, half_v};
      default: data = dr;
    endcase
  end
endmodule

// File: rtl/wb_grf.sv
// MIPS writeback stage: decode, write-data select, 32x32 GRF with write-through
// read ports, and a retired-instruction counter.
module wb_grf
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      IR_W,
  input  logic [31:0]      PC4_W,
  input  logic [31:0]      AO_W,
  input  logic [31:0]      DR_W,
  input  logic [31:0]      SH_W,
  input  logic [4:0]       RA1,
  input  logic [4:0]       RA2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic [4:0]       WB_A3,
  output logic [31:0]      WB_WD,
  output logic             WB_WE,
  output logic [CNT_W-1:0] RET_CNT
);
  logic [31:0] regs [0:31];
  logic [5:0]  op, fn;
  logic [4:0]  rt, rd, a3;
  wd_sel_e     wd_sel;
  ld_type_e    ld_type;
  logic [31:0] ld_data;
  logic        unused_ir;

  assign op        = IR_W[31:26];
  assign fn        = IR_W[5:0];
  assign rt        = IR_W[20:16];
  assign rd        = IR_W[15:11];
  assign unused_ir = ^{IR_W[25:21], IR_W[10:6]};

  always_comb begin
    a3      = 5'd0;
    wd_sel  = WD_ALU;
    ld_type = LD_W;
    case (op)
      OP_RTYPE: case (fn)
        FN_ADDU, FN_SUBU, FN_SLT: a3 = rd;
        FN_JALR:                  begin a3 = rd; wd_sel = WD_PC8;  end
        FN_MFHI, FN_MFLO:         begin a3 = rd; wd_sel = WD_HILO; end
        default:                  a3 = 5'd0;
      endcase
      OP_ORI, OP_LUI, OP_ADDIU: a3 = rt;
      OP_LW:  begin a3 = rt; wd_sel = WD_MEM; ld_type = LD_W;  end
      OP_LB:  begin a3 = rt; wd_sel = WD_MEM; ld_type = LD_B;  end
      OP_LBU: begin a3 = rt; wd_sel = WD_MEM; ld_type = LD_BU; end
      OP_LH:  begin a3 = rt; wd_sel = WD_MEM; ld_type = LD_H;  end
      OP_LHU: begin a3 = rt; wd_sel = WD_MEM; ld_type = LD_HU; end
      OP_JAL: begin a3 = 5'd31; wd_sel = WD_PC8; end
      default: a3 = 5'd0;
    endcase
  end

  load_ext u_load_ext (
    .dr      (DR_W),
    .addr    (AO_W[1:0]),
    .ld_type (ld_type),
    .data    (ld_data)
  );

  // A zero destination is the "no write" encoding, so WE falls out of A3.
  assign WB_WE = (a3 != 5'd0);
  assign WB_A3 = a3;

  always_comb begin
    case (wd_sel)
      WD_MEM:  WB_WD = ld_data;
      WD_PC8:  WB_WD = PC4_W + 32'd4;
      WD_HILO: WB_WD = SH_W;
      default: WB_WD = AO_W;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (WB_WE) begin
      regs[WB_A3] <= WB_WD;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             RET_CNT <= '0;
    else if (IR_W != '0)   RET_CNT <= RET_CNT + CNT_W'(1);
  end

  // Same-cycle write-through so decode never needs an extra forwarding hop from WB.
  always_comb begin
    if (RA1 == 5'd0)                RD1 = '0;
    else if (WB_WE && WB_A3 == RA1) RD1 = WB_WD;
    else                            RD1 = regs[RA1];
    if (RA2 == 5'd0)                RD2 = '0;
    else if (WB_WE && WB_A3 == RA2) RD2 = WB_WD;
    else                            RD2 = regs[RA2];
  end
endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: decode, load extension, link, bypass, $0, reset and counter.
module tb_wb_grf;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IR_W, PC4_W, AO_W, DR_W, SH_W;
  logic [4:0]  RA1, RA2;
  logic [31:0] RD1, RD2, WB_WD;
  logic [4:0]  WB_A3;
  logic        WB_WE;
  logic [31:0] RET_CNT;
  logic [31:0] s_rd1, s_rd2, s_wd;
  logic [4:0]  s_a3;
  logic        s_we;
  logic [3:0]  s_cnt;
  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  wb_grf #(.CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .IR_W(IR_W), .PC4_W(PC4_W), .AO_W(AO_W), .DR_W(DR_W),
    .SH_W(SH_W), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .WB_A3(WB_A3),
    .WB_WD(WB_WD), .WB_WE(WB_WE), .RET_CNT(RET_CNT)
  );

  wb_grf #(.CNT_W(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .IR_W(IR_W), .PC4_W(PC4_W), .AO_W(AO_W), .DR_W(DR_W),
    .SH_W(SH_W), .RA1(RA1), .RA2(RA2), .RD1(s_rd1), .RD2(s_rd2), .WB_A3(s_a3),
    .WB_WD(s_wd), .WB_WE(s_we), .RET_CNT(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; IR_W = '0; PC4_W = '0; AO_W = '0; DR_W = '0; SH_W = '0;
    RA1 = 5'd5; RA2 = 5'd31;
    #1;
    chk("reset_rd1", RD1, 32'h0);
    chk("reset_cnt", RET_CNT, 32'h0);
    chk("reset_we", {31'h0, WB_WE}, 32'h0);
    cyc(); cyc();
    Reset = 1'b0;

    // Bypass: ori $8, 0x1234
    IR_W = itype(6'h0d, 5'd0, 5'd8, 16'h1234); AO_W = 32'h1234; RA1 = 5'd8; RA2 = 5'd8;
    #1;
    chk("ori_a3", {27'h0, WB_A3}, 32'd8);
    chk("ori_we", {31'h0, WB_WE}, 32'd1);
    chk("byp_rd1", RD1, 32'h1234);
    chk("byp_rd2", RD2, 32'h1234);
    cyc();
    IR_W = 32'h0; #1;
    chk("grf_rd1_r8", RD1, 32'h1234);
    chk("grf_rd2_r8", RD2, 32'h1234);
    chk("cnt_after_ori", RET_CNT, 32'd1);

    // $0 protection
    IR_W = rtype(5'd1, 5'd2, 5'd0, 6'h21); AO_W = 32'hDEADBEEF; RA1 = 5'd0; #1;
    chk("r0_we", {31'h0, WB_WE}, 32'h0);
    chk("r0_a3", {27'h0, WB_A3}, 32'h0);
    chk("r0_rd1_same", RD1, 32'h0);
    cyc();
    IR_W = 32'h0; #1;
    chk("r0_rd1_next", RD1, 32'h0);
    cyc();

    // Load extension with DR_W = 0x80FF7F01
    DR_W = 32'h80FF7F01;
    IR_W = itype(6'h20, 5'd0, 5'd9, 16'h0); AO_W = 32'h103; #1;
    chk("lb_b3", WB_WD, 32'hFFFFFF80);
    cyc();
    IR_W = itype(6'h24, 5'd0, 5'd10, 16'h0); AO_W = 32'h101; RA1 = 5'd9; #1;
    chk("lbu_b1", WB_WD, 32'h0000007F);
    chk("lb_grf", RD1, 32'hFFFFFF80);
    cyc();
    IR_W = itype(6'h21, 5'd0, 5'd11, 16'h0); AO_W = 32'h102; RA1 = 5'd10; #1;
    chk("lh_h1", WB_WD, 32'hFFFF80FF);
    chk("lbu_grf", RD1, 32'h0000007F);
    cyc();
    IR_W = itype(6'h25, 5'd0, 5'd12, 16'h0); AO_W = 32'h100; RA1 = 5'd11; #1;
    chk("lhu_h0", WB_WD, 32'h00007F01);
    chk("lh_grf", RD1, 32'hFFFF80FF);
    cyc();
    IR_W = itype(6'h23, 5'd0, 5'd13, 16'h0); AO_W = 32'h100; RA1 = 5'd12; #1;
    chk("lw", WB_WD, 32'h80FF7F01);
    chk("lhu_grf", RD1, 32'h00007F01);
    cyc();

    // Link: jal then jalr $5
    IR_W = {6'h03, 26'h0}; PC4_W = 32'h00003004; RA1 = 5'd13; #1;
    chk("jal_a3", {27'h0, WB_A3}, 32'd31);
    chk("jal_wd", WB_WD, 32'h00003008);
    chk("lw_grf", RD1, 32'h80FF7F01);
    cyc();
    IR_W = rtype(5'd31, 5'd0, 5'd5, 6'h09); PC4_W = 32'hFFFFFFFC; RA1 = 5'd31; #1;
    chk("jal_grf31", RD1, 32'h00003008);
    chk("jalr_wd_wrap", WB_WD, 32'h00000000);
    cyc();
    IR_W = rtype(5'd0, 5'd0, 5'd14, 6'h10); SH_W = 32'hCAFEF00D; RA1 = 5'd5; #1;
    chk("jalr_grf5", RD1, 32'h00000000);
    chk("mfhi_wd", WB_WD, 32'hCAFEF00D);
    cyc();
    IR_W = rtype(5'd0, 5'd0, 5'd6, 6'h09); PC4_W = 32'h00004000; RA1 = 5'd14; #1;
    chk("mfhi_grf", RD1, 32'hCAFEF00D);
    cyc();
    IR_W = 32'h0; RA1 = 5'd6; #1;
    chk("jalr_grf6", RD1, 32'h00004004);
    chk("cnt_before_rst", RET_CNT, 32'd11);

    // Reset pulse between edges
    RA1 = 5'd31; RA2 = 5'd8;
    #1 Reset = 1'b1; #1;
    chk("rst_mid_rd1", RD1, 32'h0);
    chk("rst_mid_rd2", RD2, 32'h0);
    chk("rst_mid_cnt", RET_CNT, 32'h0);
    Reset = 1'b0;
    cyc();

    // Reset held across an edge: bypass still visible, no write, no count
    Reset = 1'b1; IR_W = itype(6'h0d, 5'd0, 5'd3, 16'h0055); AO_W = 32'h55; RA1 = 5'd3; #1;
    chk("rst_bypass", RD1, 32'h55);
    cyc();
    Reset = 1'b0; IR_W = 32'h0; #1;
    chk("rst_no_write", RD1, 32'h0);
    chk("rst_no_count", RET_CNT, 32'h0);

    // Counter: ori then 10 alternating nop/sw
    IR_W = itype(6'h0d, 5'd0, 5'd8, 16'h1234); AO_W = 32'h1234; RA1 = 5'd8;
    cyc();
    for (int i = 0; i < 10; i++) begin
      IR_W = (i % 2 == 1) ? itype(6'h2b, 5'd0, 5'd8, 16'h0) : 32'h0;
      AO_W = 32'h0BAD0000;
      #1;
      if (i == 1) chk("sw_we", {31'h0, WB_WE}, 32'h0);
      cyc();
    end
    IR_W = 32'h0; #1;
    chk("alt_cnt", RET_CNT, 32'd6);
    chk("alt_grf8", RD1, 32'h1234);

    // Wrap: 17 non-nops into the 4-bit counter
    #1 Reset = 1'b1; #1 Reset = 1'b0;
    IR_W = rtype(5'd1, 5'd2, 5'd0, 6'h21);
    repeat (17) cyc();
    IR_W = 32'h0; #1;
    chk("wrap_small_cnt", {28'h0, s_cnt}, 32'd1);
    chk("wrap_main_cnt", RET_CNT, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
